// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter and its address checker.
package dm_arbiter_pkg;

    localparam int MEM_TYPE_LEN = 2;

    localparam logic [MEM_TYPE_LEN-1:0] MEM_TYPE_BYTE = 2'd0;
    localparam logic [MEM_TYPE_LEN-1:0] MEM_TYPE_HALF = 2'd1;
    localparam logic [MEM_TYPE_LEN-1:0] MEM_TYPE_WORD = 2'd2;

    localparam int CPU_PORT = 0;
    localparam int DMA_PORT = 1;

    // Low address bits that must be zero for an access of the given size.
    // Unknown type codes are treated as word accesses (strictest check).
    function automatic logic [1:0] align_mask(input logic [MEM_TYPE_LEN-1:0] mem_type);
        logic [1:0] mask;
        case (mem_type)
            MEM_TYPE_BYTE: mask = 2'b00;
            MEM_TYPE_HALF: mask = 2'b01;
            default:       mask = 2'b11;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/dm_addr_check.sv
// Alignment and range check for one data-memory access.
// Also intended for the CPU exception unit (load/store address errors).
module dm_addr_check
    import dm_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 14
) (
    input  logic [31:0]             addr,
    input  logic [MEM_TYPE_LEN-1:0] mem_type,
    output logic                    misaligned,
    output logic                    out_of_range
);

    // Any set address bit at or above ADDR_WIDTH lies past the end of memory;
    // the 64-bit compare keeps ADDR_WIDTH=32 well defined.
    always_comb begin
        misaligned   = |(addr[1:0] & align_mask(mem_type));
        out_of_range = {32'd0, addr} >= (64'd1 << ADDR_WIDTH);
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter for the single-port data memory.
// Port 0 is the CPU MEM stage and has priority; port 1 is the DMA/debug
// loader, which is force-granted after MAX_WAIT consecutive refusals.
// Responses are registered and appear the cycle after acceptance.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int MAX_WAIT   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                req_valid,
    output logic [1:0]                req_ready,
    input  logic [1:0]                req_we,
    input  logic [63:0]               req_addr,
    input  logic [63:0]               req_wdata,
    input  logic [2*MEM_TYPE_LEN-1:0] req_type,
    output logic [1:0]                resp_valid,
    output logic [31:0]               resp_rdata,
    output logic                      resp_err,
    output logic                      mem_we,
    output logic [31:0]               mem_addr,
    output logic [31:0]               mem_wdata,
    output logic [MEM_TYPE_LEN-1:0]   mem_type,
    input  logic [31:0]               mem_rdata
);

    // MAX_WAIT=0 still needs a one-bit counter; it simply never leaves zero.
    localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0]       wait_cnt;
    logic                    grant_cpu;
    logic                    grant_dma;
    logic                    granted;
    logic                    sel_we;
    logic [31:0]             sel_addr;
    logic [31:0]             sel_wdata;
    logic [MEM_TYPE_LEN-1:0] sel_type;
    logic                    misaligned;
    logic                    out_of_range;
    logic                    err;

    // Priority grant: a starved DMA wins, otherwise CPU first, then DMA.
    always_comb begin
        grant_dma = req_valid[DMA_PORT] &&
                    ((wait_cnt >= WAIT_LIMIT) || !req_valid[CPU_PORT]);
        grant_cpu = req_valid[CPU_PORT] && !grant_dma;
        granted   = grant_cpu || grant_dma;
    end

    // Steer the granted port onto the memory; idle bus is a zero word access.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_type  = MEM_TYPE_WORD;
        if (grant_dma) begin
            sel_we    = req_we[DMA_PORT];
            sel_addr  = req_addr[32*DMA_PORT +: 32];
            sel_wdata = req_wdata[32*DMA_PORT +: 32];
            sel_type  = req_type[MEM_TYPE_LEN*DMA_PORT +: MEM_TYPE_LEN];
        end else if (grant_cpu) begin
            sel_we    = req_we[CPU_PORT];
            sel_addr  = req_addr[32*CPU_PORT +: 32];
            sel_wdata = req_wdata[32*CPU_PORT +: 32];
            sel_type  = req_type[MEM_TYPE_LEN*CPU_PORT +: MEM_TYPE_LEN];
        end
    end

    dm_addr_check #(
        .ADDR_WIDTH   (ADDR_WIDTH)
    ) u_addr_check (
        .addr         (sel_addr),
        .mem_type     (sel_type),
        .misaligned   (misaligned),
        .out_of_range (out_of_range)
    );

    // Errored accesses never write; writes are also blocked while in reset
    // so a request caught by reset cannot disturb memory.
    always_comb begin
        err       = granted && (misaligned || out_of_range);
        req_ready = {grant_dma, grant_cpu};
        mem_we    = sel_we && !err && !reset;
        mem_addr  = sel_addr;
        mem_wdata = sel_wdata;
        mem_type  = sel_type;
    end

    // Count consecutive refusals of a waiting DMA request, saturating at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (req_valid[DMA_PORT] && !grant_dma) begin
            if (wait_cnt != WAIT_LIMIT) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
        end else begin
            wait_cnt <= '0;
        end
    end

    // Register the completion of this cycle's access for the requester.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= req_ready;
            resp_err   <= err;
            resp_rdata <= (granted && !sel_we && !err) ? mem_rdata : '0;
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Testbench for dm_arbiter: directed table, hand-written corner sequences
// and a randomized run against a transaction-level model of the arbiter.
module tb_dm_arbiter;
    import dm_arbiter_pkg::*;

    localparam int ADDR_WIDTH = 14;
    localparam int MAX_WAIT   = 4;
    localparam int MEM_WORDS  = 4096;
    localparam int N_RANDOM   = 2000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [1:0]  req_we = '0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [3:0]  req_type = '0;
    logic [1:0]  resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_type;
    logic [31:0] mem_rdata;
    logic        mem_clr = 1'b1;

    logic [31:0] mem    [0:MEM_WORDS-1];
    logic [31:0] shadow [0:MEM_WORDS-1];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dm_arbiter #(.ADDR_WIDTH(ADDR_WIDTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_type(req_type),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_type(mem_type), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] lane_read(input logic [31:0] w, input logic [1:0] off,
                                              input logic [1:0] ty);
        logic [31:0] s;
        s = w >> (8 * off);
        if (ty == MEM_TYPE_BYTE) return s & 32'h0000_00FF;
        if (ty == MEM_TYPE_HALF) return s & 32'h0000_FFFF;
        return w;
    endfunction

    function automatic logic [31:0] lane_write(input logic [31:0] w, input logic [1:0] off,
                                               input logic [1:0] ty, input logic [31:0] d);
        logic [31:0] m;
        m = (ty == MEM_TYPE_BYTE) ? 32'hFF : (ty == MEM_TYPE_HALF) ? 32'hFFFF : 32'hFFFF_FFFF;
        return (w & ~(m << (8 * off))) | ((d & m) << (8 * off));
    endfunction

    // Byte-addressed memory with combinational read, as seen by the arbiter.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
        end else if (mem_we) begin
            mem[mem_addr[13:2]] <= lane_write(mem[mem_addr[13:2]], mem_addr[1:0], mem_type, mem_wdata);
        end
    end
    assign mem_rdata = lane_read(mem[mem_addr[13:2]], mem_addr[1:0], mem_type);

    // An access faults if its address is not a multiple of its size or lies past memory.
    function automatic logic model_err(input logic [31:0] a, input logic [1:0] ty);
        int unsigned sz;
        sz = (ty == MEM_TYPE_BYTE) ? 1 : (ty == MEM_TYPE_HALF) ? 2 : 4;
        return ((a % sz) != 0) || (a >= (32'd1 << ADDR_WIDTH));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int p, input logic v, input logic we, input logic [31:0] a,
                         input logic [1:0] ty, input logic [31:0] wd);
        req_valid[p]        = v;
        req_we[p]           = we;
        req_addr[32*p +: 32] = a;
        req_wdata[32*p +: 32] = wd;
        req_type[2*p +: 2]  = ty;
    endtask

    task automatic idle();
        drive(0, 1'b0, 1'b0, 32'd0, MEM_TYPE_WORD, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, MEM_TYPE_WORD, 32'd0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [1:0]  ty;
        logic [31:0] wdata;
        logic        exp_we;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    function automatic vec_t mk(input int p, input logic we, input logic [31:0] a, input logic [1:0] ty,
                                input logic [31:0] wd, input logic ewe, input logic [31:0] erd,
                                input logic eerr);
        vec_t v;
        v.port = p; v.we = we; v.addr = a; v.ty = ty; v.wdata = wd;
        v.exp_we = ewe; v.exp_rdata = erd; v.exp_err = eerr;
        return v;
    endfunction

    vec_t tbl [17];

    initial begin
        logic [1:0]  cur_v, cur_we, cur_ty, hold;
        logic [31:0] cur_a  [2];
        logic [31:0] cur_wd [2];
        logic [1:0]  prev_rv, exp_ready;
        logic [31:0] prev_rd, exp_rd;
        logic        prev_err, exp_e, exp_mwe;
        int          refused, gp;

        tbl[0]  = mk(0, 1, 32'h10,   MEM_TYPE_WORD, 32'hDEAD_BEEF, 1, 32'h0,         0);
        tbl[1]  = mk(1, 1, 32'h20,   MEM_TYPE_WORD, 32'h1234_5678, 1, 32'h0,         0);
        tbl[2]  = mk(0, 0, 32'h10,   MEM_TYPE_WORD, 32'h0,         0, 32'hDEAD_BEEF, 0);
        tbl[3]  = mk(0, 1, 32'h13,   MEM_TYPE_BYTE, 32'h0000_00AA, 1, 32'h0,         0);
        tbl[4]  = mk(0, 0, 32'h10,   MEM_TYPE_WORD, 32'h0,         0, 32'hAAAD_BEEF, 0);
        tbl[5]  = mk(1, 1, 32'h21,   MEM_TYPE_HALF, 32'h0000_FFFF, 0, 32'h0,         1);
        tbl[6]  = mk(1, 0, 32'h20,   MEM_TYPE_WORD, 32'h0,         0, 32'h1234_5678, 0);
        tbl[7]  = mk(0, 0, 32'h4000, MEM_TYPE_WORD, 32'h0,         0, 32'h0,         1);
        tbl[8]  = mk(0, 0, 32'h12,   MEM_TYPE_HALF, 32'h0,         0, 32'h0000_AAAD, 0);
        tbl[9]  = mk(1, 0, 32'h11,   MEM_TYPE_BYTE, 32'h0,         0, 32'h0000_00BE, 0);
        tbl[10] = mk(0, 1, 32'h22,   MEM_TYPE_WORD, 32'h5555_5555, 0, 32'h0,         1);
        tbl[11] = mk(0, 1, 32'h3FFC, MEM_TYPE_WORD, 32'hCAFE_F00D, 1, 32'h0,         0);
        tbl[12] = mk(1, 0, 32'h3FFC, MEM_TYPE_WORD, 32'h0,         0, 32'hCAFE_F00D, 0);
        tbl[13] = mk(0, 0, 32'h3FFF, MEM_TYPE_BYTE, 32'h0,         0, 32'h0000_00CA, 0);
        tbl[14] = mk(1, 0, 32'h20,   MEM_TYPE_WORD, 32'h0,         0, 32'h1234_5678, 0);
        tbl[15] = mk(0, 0, 32'h3FFE, MEM_TYPE_HALF, 32'h0,         0, 32'h0000_CAFE, 0);
        tbl[16] = mk(1, 1, 32'h8000_0000, MEM_TYPE_BYTE, 32'h77,   0, 32'h0,         1);

        for (int i = 0; i < MEM_WORDS; i++) shadow[i] = '0;

        // Reset values
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err",   32'(resp_err), 32'd0);
        next_cycle();
        reset   = 1'b0;
        mem_clr = 1'b0;
        @(negedge clk);
        check("idle_ready",    32'(req_ready), 32'd0);
        check("idle_mem_we",   32'(mem_we), 32'd0);
        check("idle_mem_addr", mem_addr, 32'd0);
        check("idle_mem_type", 32'(mem_type), 32'(MEM_TYPE_WORD));
        check("idle_resp",     32'(resp_valid), 32'd0);
        next_cycle();

        // Directed table: one access, then an idle cycle carrying its response
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].port, 1'b1, tbl[i].we, tbl[i].addr, tbl[i].ty, tbl[i].wdata);
            @(negedge clk);
            check($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(2'b01 << tbl[i].port));
            check($sformatf("tbl%0d_mem_we", i), 32'(mem_we), 32'(tbl[i].exp_we));
            if (tbl[i].exp_we)
                shadow[tbl[i].addr[13:2]] = lane_write(shadow[tbl[i].addr[13:2]], tbl[i].addr[1:0],
                                                       tbl[i].ty, tbl[i].wdata);
            next_cycle();
            idle();
            @(negedge clk);
            check($sformatf("tbl%0d_resp_valid", i), 32'(resp_valid), 32'(2'b01 << tbl[i].port));
            check($sformatf("tbl%0d_rdata", i), resp_rdata, tbl[i].exp_rdata);
            check($sformatf("tbl%0d_err", i), 32'(resp_err), 32'(tbl[i].exp_err));
            next_cycle();
        end

        // Back-to-back write then read of the same word
        drive(0, 1'b1, 1'b1, 32'h30, MEM_TYPE_WORD, 32'h0BAD_F00D);
        @(negedge clk);
        check("b2b_wr_mem_we", 32'(mem_we), 32'd1);
        shadow[12] = 32'h0BAD_F00D;
        next_cycle();
        drive(0, 1'b1, 1'b0, 32'h30, MEM_TYPE_WORD, 32'h0);
        @(negedge clk);
        check("b2b_wr_resp",  32'(resp_valid), 32'd1);
        check("b2b_rd_ready", 32'(req_ready), 32'd1);
        next_cycle();
        idle();
        @(negedge clk);
        check("b2b_rd_resp",  32'(resp_valid), 32'd1);
        check("b2b_rd_rdata", resp_rdata, 32'h0BAD_F00D);
        next_cycle();

        // Both ports valid continuously: DMA gets every (MAX_WAIT+1)-th slot
        drive(0, 1'b1, 1'b0, 32'h10, MEM_TYPE_WORD, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h20, MEM_TYPE_WORD, 32'h0);
        prev_rv = 2'b00;
        for (int i = 0; i < 15; i++) begin
            exp_ready = ((i % (MAX_WAIT + 1)) == MAX_WAIT) ? 2'b10 : 2'b01;
            @(negedge clk);
            check($sformatf("starve%0d_ready", i), 32'(req_ready), 32'(exp_ready));
            check($sformatf("starve%0d_resp", i), 32'(resp_valid), 32'(prev_rv));
            if (prev_rv != 2'b00)
                check($sformatf("starve%0d_rdata", i), resp_rdata, (prev_rv == 2'b01) ? shadow[4] : shadow[8]);
            prev_rv = exp_ready;
            next_cycle();
        end

        // Reset while a refused DMA is waiting and a CPU read is being accepted
        idle();
        next_cycle();
        drive(0, 1'b1, 1'b0, 32'h10, MEM_TYPE_WORD, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h20, MEM_TYPE_WORD, 32'h0);
        repeat (3) next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("rstmid_resp_valid", 32'(resp_valid), 32'd0);
        check("rstmid_resp_err",   32'(resp_err), 32'd0);
        check("rstmid_resp_rdata", resp_rdata, 32'd0);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            exp_ready = (i == MAX_WAIT) ? 2'b10 : 2'b01;
            check($sformatf("rstmid%0d_ready", i), 32'(req_ready), 32'(exp_ready));
            next_cycle();
        end
        idle();
        repeat (2) next_cycle();

        // Randomized traffic against a transaction-level model
        hold = 2'b00; refused = 0;
        prev_rv = 2'b00; prev_rd = '0; prev_err = 1'b0;
        cur_v = '0; cur_we = '0; cur_ty = '0;
        cur_a[0] = '0; cur_a[1] = '0; cur_wd[0] = '0; cur_wd[1] = '0;
        for (int n = 0; n < N_RANDOM; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!hold[p]) begin
                    int r;
                    cur_v[p]  = (p == 0) ? (($urandom % 4) != 0) : (($urandom % 3) != 0);
                    cur_we[p] = $urandom % 2;
                    cur_ty[p] = 2'($urandom % 3);
                    r = $urandom % 16;
                    if (r == 0)      cur_a[p] = 32'h4000 + ($urandom % 16);
                    else if (r == 1) cur_a[p] = 32'h8000_0000 | ($urandom % 64);
                    else             cur_a[p] = $urandom_range(0, 63);
                    cur_wd[p] = $urandom;
                end
                drive(p, cur_v[p], cur_we[p], cur_a[p], cur_ty[p], cur_wd[p]);
            end

            if (cur_v[1] && (refused >= MAX_WAIT || !cur_v[0])) gp = 1;
            else if (cur_v[0])                                  gp = 0;
            else if (cur_v[1])                                  gp = 1;
            else                                                gp = -1;
            exp_ready = (gp < 0) ? 2'b00 : (2'b01 << gp);
            exp_e   = (gp >= 0) && model_err(cur_a[gp < 0 ? 0 : gp], cur_ty[gp < 0 ? 0 : gp]);
            exp_mwe = (gp >= 0) && cur_we[gp < 0 ? 0 : gp] && !exp_e;
            exp_rd  = '0;
            if (gp >= 0 && !cur_we[gp] && !exp_e)
                exp_rd = lane_read(shadow[cur_a[gp][13:2]], cur_a[gp][1:0], cur_ty[gp]);

            @(negedge clk);
            check("rnd_ready",      32'(req_ready), 32'(exp_ready));
            check("rnd_mem_we",     32'(mem_we), 32'(exp_mwe));
            check("rnd_mem_addr",   mem_addr, (gp >= 0) ? cur_a[gp] : 32'd0);
            check("rnd_resp_valid", 32'(resp_valid), 32'(prev_rv));
            check("rnd_resp_rdata", resp_rdata, prev_rd);
            check("rnd_resp_err",   32'(resp_err), 32'(prev_err));

            @(posedge clk);
            if (exp_mwe)
                shadow[cur_a[gp][13:2]] = lane_write(shadow[cur_a[gp][13:2]], cur_a[gp][1:0],
                                                     cur_ty[gp], cur_wd[gp]);
            refused  = (cur_v[1] && gp != 1) ? ((refused < MAX_WAIT) ? refused + 1 : MAX_WAIT) : 0;
            hold[0]  = cur_v[0] && gp != 0;
            hold[1]  = cur_v[1] && gp != 1;
            prev_rv  = exp_ready;
            prev_rd  = exp_rd;
            prev_err = exp_e;
            #1;
        end
        idle();
        @(negedge clk);
        check("rnd_last_resp", 32'(resp_valid), 32'(prev_rv));
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
